cfglut5_loader: RTL and testbench
=================================

CFGLUT5_LOADER -- requirements
Module: cfglut5_loader

Interface
REQ-001 The module SHALL have parameter N_LUT, default 1, giving the number of daisy-chained CFGLUT5 cells (CDO of cell k feeds CDI of cell k+1); legal range is 1..8.
REQ-002 The module SHALL have parameter VERIFY, default 1; when 1, a recirculating readback pass follows each load.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 IN_DATA  input  32  truth table for one CFGLUT5 (INIT[31:0]).
REQ-006 IN_VALID  input  1  IN_DATA valid.
REQ-007 IN_READY  output  1  word accepted on an edge where IN_VALID and IN_READY are both 1.
REQ-008 CE  output  1  shift enable to every cell in the chain.
REQ-009 CDI  output  1  serial data into the first cell of the chain.
REQ-010 CDO  input  1  serial data out of the last cell of the chain (its INIT[31]).
REQ-011 BUSY  output  1  high in LOAD or CHECK.
REQ-012 DONE  output  1  one-cycle pulse at session end.
REQ-013 ERR  output  1  sticky readback mismatch flag.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, CHECK; CE, CDI, DONE and ERR SHALL be registered.
REQ-015 A session SHALL accept exactly N_LUT words; the first word accepted SHALL end in the last cell of the chain, and the last word accepted in the first cell.
REQ-016 Each word SHALL be shifted MSB first: one bit per edge with CE=1, IN_DATA[31] first and IN_DATA[0] last.
REQ-017 IDLE: IN_READY=1; acceptance SHALL enter LOAD, clear ERR, and drive CE=1 and CDI=IN_DATA[31] from that same edge.
REQ-018 LOAD SHALL use a 32-bit shift register plus a 1-deep holding register; IN_READY=1 only while the holding register is empty and fewer than N_LUT words have been accepted.
REQ-019 After the 32nd bit of a word, a held word SHALL continue shifting with no CE gap; if no word is held and the session is incomplete, CE SHALL be 0 until the next acceptance (pause, no bits lost).
REQ-020 A 32*N_LUT-bit shadow register SHALL capture every bit driven on CDI during LOAD.
REQ-021 After the final load shift: if VERIFY=0, go IDLE with DONE=1 for one cycle; if VERIFY=1, go CHECK with CE held at 1 and no gap.
REQ-022 CHECK SHALL last exactly 32*N_LUT CE cycles with CDI=CDO (recirculate), leaving chain contents unchanged on completion.
REQ-023 On every CHECK edge, CDO SHALL be compared with the shadow MSB, and the shadow SHALL rotate left by one; any mismatch SHALL set ERR (sticky until the next session start).
REQ-024 The edge that performs the last CHECK shift SHALL drop CE, pulse DONE and return to IDLE; ERR SHALL be valid in the DONE cycle.
REQ-025 IN_READY SHALL be 0 in CHECK and once N_LUT words are accepted; IN_VALID in those states SHALL be ignored.
REQ-026 Latency with back-to-back words: DONE at acceptance edge + 32*N_LUT (VERIFY=0) or + 64*N_LUT (VERIFY=1).
REQ-027 The bit counter SHALL count 0..31 and then wrap; the word counter SHALL be sized for N_LUT.

Reset
REQ-028 RST_N low SHALL immediately force IDLE with CE=0, CDI=0, DONE=0, ERR=0 and BUSY=0, and IN_READY SHALL be gated to 0 while RST_N is low.
REQ-029 Reset mid-LOAD or mid-CHECK SHALL abort the session without a DONE pulse; chain contents are then undefined and a new session is required.
REQ-030 After release, IN_READY SHALL be 1 in the first cycle.

Verification
REQ-031 Bench SHALL model the CFGLUT5 chain behaviourally and cover:
- N_LUT=1, VERIFY=0, word 32'hDEADBEEF -> CE high 32 cycles; CDI sequence 1,1,0,1,...; cell INIT=32'hDEADBEEF; DONE at accept+32; ERR=0.
- N_LUT=2, VERIFY=1, back-to-back words 32'h12345678 then 32'h8000_0001 -> last cell 12345678, first cell 80000001; no CE gap; DONE at accept+128; ERR=0; contents unchanged after CHECK.
- N_LUT=2, IN_VALID gapped 10 cycles between words -> CE low exactly 10 cycles; final contents correct.
- VERIFY=1, model forces CDO bit 5 of the CHECK pass inverted -> ERR=1 at DONE; ERR clears on the next session's first acceptance.
- RST_N low at LOAD bit 17 -> CE=0 asynchronously; no DONE; IN_READY=1 in the first cycle after release; a fresh load of 32'h0000FFFF succeeds.
- IN_VALID held high during CHECK -> IN_READY=0 and no extra word accepted.

Source files
------------

// File: rtl/cfglut5_loader_if.sv
// Word-stream handshake into the CFGLUT5 chain loader.
// The loader is the slave; whoever supplies truth tables is the master.
interface cfglut5_loader_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cfglut5_loader.sv
// Serial loader for a daisy chain of N_LUT CFGLUT5 cells, with an optional
// recirculating readback pass that compares the chain against a shadow copy.
module cfglut5_loader #(
    parameter int unsigned N_LUT  = 1,
    parameter bit          VERIFY = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    cfglut5_loader_if.slave i_word,
    output logic            o_ce,
    output logic            o_cdi,
    input  logic            i_cdo,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);
    localparam int unsigned    LEN    = 32 * N_LUT;
    localparam int unsigned    WCW    = $clog2(N_LUT + 1);
    localparam int unsigned    CCW    = $clog2(LEN);
    localparam logic [WCW-1:0] W_ALL  = WCW'(N_LUT);
    localparam logic [CCW-1:0] C_LAST = CCW'(LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [31:0]    r_shift, w_shift_nxt;
    logic [31:0]    r_hold, w_hold_nxt;
    logic           r_hold_vld, w_hold_vld_nxt;
    logic [4:0]     r_bit, w_bit_nxt;
    logic [WCW-1:0] r_words, w_words_nxt;
    logic [LEN-1:0] r_shadow, w_shadow_nxt;
    logic [CCW-1:0] r_chk, w_chk_nxt;
    logic           r_ce, w_ce_nxt;
    logic           r_cdi, w_cdi_nxt;
    logic           r_done, w_done_nxt;
    logic           r_err, w_err_nxt;
    logic           w_ready;
    logic           w_accept;

    assign w_ready = i_rst_n &&
                     ((r_state == ST_IDLE) ||
                      (r_state == ST_LOAD && !r_hold_vld && r_words != W_ALL));
    assign w_accept = i_word.in_valid && w_ready;

    assign i_word.in_ready = w_ready;
    assign o_ce   = r_ce;
    assign o_cdi  = r_cdi;
    assign o_done = r_done;
    assign o_err  = r_err;
    assign o_busy = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_hold_nxt     = r_hold;
        w_hold_vld_nxt = r_hold_vld;
        w_bit_nxt      = r_bit;
        w_words_nxt    = r_words;
        w_shadow_nxt   = r_shadow;
        w_chk_nxt      = r_chk;
        w_ce_nxt       = r_ce;
        w_cdi_nxt      = r_cdi;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;

        case (r_state)
            ST_IDLE: begin
                w_ce_nxt  = 1'b0;
                w_cdi_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt    = ST_LOAD;
                    w_err_nxt      = 1'b0;
                    w_ce_nxt       = 1'b1;
                    w_cdi_nxt      = i_word.in_data[31];
                    w_shift_nxt    = {i_word.in_data[30:0], 1'b0};
                    w_bit_nxt      = '0;
                    w_words_nxt    = WCW'(1);
                    w_hold_vld_nxt = 1'b0;
                end
            end

            ST_LOAD: begin
                if (w_accept) begin
                    w_words_nxt = r_words + 1'b1;
                end
                // Mid-word arrivals park in the holding register; an arrival on the
                // last bit of a word or during a pause goes straight to the shifter.
                if (w_accept && r_ce && r_bit != 5'd31) begin
                    w_hold_nxt     = i_word.in_data;
                    w_hold_vld_nxt = 1'b1;
                end
                if (r_ce) begin
                    w_shadow_nxt = {r_shadow[LEN-2:0], r_cdi};
                    if (r_bit != 5'd31) begin
                        w_cdi_nxt   = r_shift[31];
                        w_shift_nxt = {r_shift[30:0], 1'b0};
                        w_bit_nxt   = r_bit + 1'b1;
                    end else if (r_hold_vld) begin
                        w_cdi_nxt      = r_hold[31];
                        w_shift_nxt    = {r_hold[30:0], 1'b0};
                        w_bit_nxt      = '0;
                        w_hold_vld_nxt = 1'b0;
                    end else if (w_accept) begin
                        w_cdi_nxt   = i_word.in_data[31];
                        w_shift_nxt = {i_word.in_data[30:0], 1'b0};
                        w_bit_nxt   = '0;
                    end else if (r_words != W_ALL) begin
                        w_ce_nxt  = 1'b0;
                        w_cdi_nxt = 1'b0;
                    end else if (VERIFY) begin
                        w_state_nxt = ST_CHECK;
                        w_chk_nxt   = '0;
                        w_cdi_nxt   = w_shadow_nxt[LEN-1];
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_ce_nxt    = 1'b0;
                        w_cdi_nxt   = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end else if (w_accept) begin
                    w_ce_nxt    = 1'b1;
                    w_cdi_nxt   = i_word.in_data[31];
                    w_shift_nxt = {i_word.in_data[30:0], 1'b0};
                    w_bit_nxt   = '0;
                end
            end

            ST_CHECK: begin
                if (i_cdo != r_shadow[LEN-1]) begin
                    w_err_nxt = 1'b1;
                end
                // CDI is registered, so the bit fed back is the shadow's next MSB,
                // which is what CDO presents in the following cycle on an intact chain.
                w_shadow_nxt = {r_shadow[LEN-2:0], r_shadow[LEN-1]};
                w_cdi_nxt    = r_shadow[LEN-2];
                if (r_chk == C_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_ce_nxt    = 1'b0;
                    w_cdi_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_chk_nxt = r_chk + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_ce_nxt    = 1'b0;
                w_cdi_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_bit      <= '0;
            r_words    <= '0;
            r_shadow   <= '0;
            r_chk      <= '0;
            r_ce       <= 1'b0;
            r_cdi      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_hold     <= w_hold_nxt;
            r_hold_vld <= w_hold_vld_nxt;
            r_bit      <= w_bit_nxt;
            r_words    <= w_words_nxt;
            r_shadow   <= w_shadow_nxt;
            r_chk      <= w_chk_nxt;
            r_ce       <= w_ce_nxt;
            r_cdi      <= w_cdi_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end
endmodule

// File: tb/tb_cfglut5_loader.sv
// Directed bench: two loaders (1 cell no readback, 2 cells with readback)
// each driving a behavioural CFGLUT5 chain model.
module tb_cfglut5_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic ce_a, cdi_a, cdo_a, busy_a, done_a, err_a;
    logic ce_b, cdi_b, cdo_b, busy_b, done_b, err_b;

    cfglut5_loader_if u_if_a ();
    cfglut5_loader_if u_if_b ();

    cfglut5_loader #(.N_LUT(1), .VERIFY(1'b0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_a), .i_word(u_if_a),
        .o_ce(ce_a), .o_cdi(cdi_a), .i_cdo(cdo_a),
        .o_busy(busy_a), .o_done(done_a), .o_err(err_a)
    );

    cfglut5_loader #(.N_LUT(2), .VERIFY(1'b1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_b), .i_word(u_if_b),
        .o_ce(ce_b), .o_cdi(cdi_b), .i_cdo(cdo_b),
        .o_busy(busy_b), .o_done(done_b), .o_err(err_b)
    );

    // Chain models: bit [MSB] is INIT[31] of the last cell, new bits enter at [0].
    logic [31:0] chain_a = '0;
    logic [63:0] chain_b = '0;
    int unsigned shifts_b = 0;
    logic        inj_en;

    always @(posedge clk) if (ce_a) chain_a <= {chain_a[30:0], cdi_a};

    always @(posedge clk) begin
        if (ce_b) chain_b <= {chain_b[62:0], cdi_b};
        if (!busy_b) shifts_b <= 0;
        else if (ce_b) shifts_b <= shifts_b + 1;
    end

    assign cdo_a = chain_a[31];
    // Sixth readback bit (index 5) is inverted when injection is enabled.
    assign cdo_b = chain_b[63] ^ (inj_en && shifts_b == 64 + 5);

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int unsigned r_hi, r_lo, r_at, r_cnt, rdy_hi;
    logic        r_err, e0;
    logic [31:0] r_cdi;

    // Observe one loader for ncyc cycles, starting with the cycle after the call's edge.
    task automatic mon(input bit sel, input int unsigned ncyc,
                       output int unsigned ce_hi, output int unsigned ce_lo,
                       output int unsigned done_at, output int unsigned done_cnt,
                       output logic err_d, output logic [31:0] cdi_w);
        ce_hi = 0; ce_lo = 0; done_at = 0; done_cnt = 0; err_d = 1'b0; cdi_w = '0;
        for (int unsigned i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (sel ? ce_b : ce_a) ce_hi++;
            else if (sel ? busy_b : busy_a) ce_lo++;
            if (i < 32) cdi_w = {cdi_w[30:0], (sel ? cdi_b : cdi_a)};
            if (sel ? done_b : done_a) begin
                done_at = i;
                done_cnt++;
                err_d = sel ? err_b : err_a;
            end
        end
    endtask

    task automatic load2_b(input logic [31:0] w1, input logic [31:0] w2, output logic err_start);
        @(negedge clk);
        u_if_b.in_data = w1; u_if_b.in_valid = 1'b1;
        @(posedge clk);
        fork
            mon(1'b1, 135, r_hi, r_lo, r_at, r_cnt, r_err, r_cdi);
            begin
                @(negedge clk);
                u_if_b.in_data = w2;
                err_start = err_b;
                @(negedge clk);
                u_if_b.in_valid = 1'b0;
            end
        join
    endtask

    initial begin
        inj_en = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        u_if_a.in_data = '0; u_if_a.in_valid = 1'b0;
        u_if_b.in_data = '0; u_if_b.in_valid = 1'b0;
        rdy_hi = 0;

        repeat (3) @(negedge clk);
        check_val("rst_a_outs", 64'({ce_a, cdi_a, done_a, err_a, busy_a, u_if_a.in_ready}), 64'd0);
        check_val("rst_b_outs", 64'({ce_b, cdi_b, done_b, err_b, busy_b, u_if_b.in_ready}), 64'd0);
        rst_a = 1'b1; rst_b = 1'b1;
        #1;
        check_val("rdy_a_after_rst", 64'(u_if_a.in_ready), 64'd1);
        check_val("rdy_b_after_rst", 64'(u_if_b.in_ready), 64'd1);

        // One cell, no readback
        @(negedge clk);
        u_if_a.in_data = 32'hDEADBEEF; u_if_a.in_valid = 1'b1;
        @(posedge clk); #1 u_if_a.in_valid = 1'b0;
        mon(1'b0, 40, r_hi, r_lo, r_at, r_cnt, r_err, r_cdi);
        check_val("t1_ce_cycles", 64'(r_hi), 64'd32);
        check_val("t1_ce_gaps", 64'(r_lo), 64'd0);
        check_val("t1_cdi_seq", 64'(r_cdi), 64'hDEADBEEF);
        check_val("t1_done_at", 64'(r_at), 64'd32);
        check_val("t1_done_cnt", 64'(r_cnt), 64'd1);
        check_val("t1_err", 64'(r_err), 64'd0);
        check_val("t1_cell", 64'(chain_a), 64'hDEADBEEF);

        // Two cells, back-to-back words, IN_VALID held high through CHECK
        @(negedge clk);
        u_if_b.in_data = 32'h12345678; u_if_b.in_valid = 1'b1;
        @(posedge clk);
        fork
            mon(1'b1, 140, r_hi, r_lo, r_at, r_cnt, r_err, r_cdi);
            begin
                @(negedge clk); u_if_b.in_data = 32'h80000001;
                @(negedge clk); u_if_b.in_valid = 1'b0;
                repeat (69) @(negedge clk);
                u_if_b.in_data = 32'hCAFEF00D; u_if_b.in_valid = 1'b1;
                for (int i = 0; i < 57; i++) begin
                    if (u_if_b.in_ready) rdy_hi++;
                    @(negedge clk);
                end
                u_if_b.in_valid = 1'b0;
            end
        join
        check_val("t2_ce_cycles", 64'(r_hi), 64'd128);
        check_val("t2_ce_gaps", 64'(r_lo), 64'd0);
        check_val("t2_done_at", 64'(r_at), 64'd128);
        check_val("t2_done_cnt", 64'(r_cnt), 64'd1);
        check_val("t2_err", 64'(r_err), 64'd0);
        check_val("t2_chain", chain_b, 64'h12345678_80000001);
        check_val("t6_rdy_in_check", 64'(rdy_hi), 64'd0);
        check_val("t6_no_extra_word", 64'(busy_b), 64'd0);

        // Two cells with a 10-cycle input gap between words
        @(negedge clk);
        u_if_b.in_data = 32'hA5A50F0F; u_if_b.in_valid = 1'b1;
        @(posedge clk);
        fork
            mon(1'b1, 150, r_hi, r_lo, r_at, r_cnt, r_err, r_cdi);
            begin
                @(negedge clk); u_if_b.in_valid = 1'b0;
                repeat (41) @(negedge clk);
                u_if_b.in_data = 32'h3C3C9669; u_if_b.in_valid = 1'b1;
                @(negedge clk); u_if_b.in_valid = 1'b0;
            end
        join
        check_val("t3_ce_gap", 64'(r_lo), 64'd10);
        check_val("t3_ce_cycles", 64'(r_hi), 64'd128);
        check_val("t3_done_at", 64'(r_at), 64'd138);
        check_val("t3_err", 64'(r_err), 64'd0);
        check_val("t3_chain", chain_b, 64'hA5A50F0F_3C3C9669);

        // Readback fault, then sticky ERR cleared by the next session
        inj_en = 1'b1;
        load2_b(32'hC3C35A5A, 32'h0F0FF0F0, e0);
        check_val("t4_err_at_done", 64'(r_err), 64'd1);
        check_val("t4_done_at", 64'(r_at), 64'd128);
        inj_en = 1'b0;
        @(negedge clk);
        check_val("t4_err_sticky", 64'(err_b), 64'd1);
        load2_b(32'h11112222, 32'h33334444, e0);
        check_val("t4_err_cleared", 64'(e0), 64'd0);
        check_val("t4_clean_err", 64'(r_err), 64'd0);
        check_val("t4_clean_done", 64'(r_at), 64'd128);
        check_val("t4_clean_chain", chain_b, 64'h11112222_33334444);

        // Reset during LOAD bit 17 of the single-cell loader
        @(negedge clk);
        u_if_a.in_data = 32'hFFFF0000; u_if_a.in_valid = 1'b1;
        @(posedge clk); #1 u_if_a.in_valid = 1'b0;
        repeat (18) @(negedge clk);
        check_val("t5_bit17", 64'(cdi_a), 64'd0);
        check_val("t5_ce_before", 64'(ce_a), 64'd1);
        rst_a = 1'b0;
        #1;
        check_val("t5_async_ce", 64'(ce_a), 64'd0);
        check_val("t5_async_outs", 64'({busy_a, done_a, u_if_a.in_ready}), 64'd0);
        mon(1'b0, 6, r_hi, r_lo, r_at, r_cnt, r_err, r_cdi);
        check_val("t5_no_done", 64'(r_cnt), 64'd0);
        rst_a = 1'b1;
        #1;
        check_val("t5_rdy_release", 64'(u_if_a.in_ready), 64'd1);
        u_if_a.in_data = 32'h0000FFFF; u_if_a.in_valid = 1'b1;
        @(posedge clk); #1 u_if_a.in_valid = 1'b0;
        mon(1'b0, 40, r_hi, r_lo, r_at, r_cnt, r_err, r_cdi);
        check_val("t5_reload_done", 64'(r_at), 64'd32);
        check_val("t5_reload_ce", 64'(r_hi), 64'd32);
        check_val("t5_reload_cell", 64'(chain_a), 64'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
